bj_card_dealer: RTL and testbench
=================================

// Module: bj_card_dealer
// PURPOSE
//  Upstream card source for the blackjack hand register. Draws pseudo-random ranks from a free-running
//  16-bit LFSR and writes them one at a time into hand slots 0..3 through the register's LD/POS/D load port.
//  Clears the hand on NEW_HAND. Reads the hand total CNT back to flag a bust and stop dealing.
//  Rank code: 1=A, 2..9 = pips, 0/10/11/12 = T/J/Q/K. Codes 13..15 are never emitted; 4'hF marks an empty slot.
// PARAMETERS
//  SEED       16'hACE1  LFSR value loaded on reset; must be non-zero
//  MAX_TRIES  8         draw attempts before the fallback card is used (range 1..15)
//  BUST_LIMIT 21        CNT > BUST_LIMIT asserts BUST
// PORTS
//  CLK       in   1   clock; all state updates on posedge
//  RST_N     in   1   asynchronous, active-low reset
//  DEAL      in   1   deal request; rising-edge detected internally
//  NEW_HAND  in   1   clear hand; level, sampled every cycle
//  CNT       in   6   hand total from the hand register
//  LD        out  1   load strobe to the hand register
//  POS       out  2   slot index to load
//  D         out  4   rank code to load
//  CLR       out  1   clear strobe to the hand register (sets slots to 4'hF)
//  CARDS     out  3   cards in the current hand, 0..4
//  FULL      out  1   CARDS == 4
//  BUST      out  1   CNT > BUST_LIMIT, valid only while a hand is live
//  BUSY      out  1   FSM is not in IDLE
// BEHAVIOUR
//  Reset
//  - Async assert: FSM=CLEAR, LFSR=SEED, CARDS=0, card reg=0, deal_q=0, try_cnt=0.
//  - Outputs during reset: CLR=1, LD=0, POS=0, D=0, FULL=0, BUST=0, BUSY=1.
//  LFSR
//  - Fibonacci, shifts left every cycle, never gated. Next = {q[14:0], q[15]^q[13]^q[12]^q[10]}.
//  DEAL edge
//  - deal_req = DEAL & ~deal_q; deal_q <= DEAL every cycle.
//  - An edge that arrives outside IDLE is dropped, not queued.
//  FSM states and transitions
//  - CLEAR: CLR=1 for exactly one cycle; CARDS<=0; next state IDLE.
//  - IDLE:  if deal_req & !FULL & !BUST -> DRAW with try_cnt<=0. Otherwise stay.
//  - DRAW:  sample lfsr[3:0] in this cycle.
//      - Value <= 12: card<=value -> LOAD.
//      - Else if try_cnt == MAX_TRIES-1: card<=value-13 (result 0..2) -> LOAD.
//      - Else: try_cnt++ and stay in DRAW.
//  - LOAD:  LD=1 for one cycle, POS=CARDS[1:0], D=card; CARDS++ at the end of the cycle -> IDLE.
//  Priority and latency
//  - NEW_HAND=1 in any state forces next state CLEAR. It outranks a DEAL edge in the same cycle.
//  - NEW_HAND aborts DRAW or LOAD. From LOAD, LD is still high in that cycle and the load lands, but CLEAR
//    clears it on the next cycle.
//  - Latency: DEAL edge sampled at edge k -> LD high in cycle k+2 at best, k+1+MAX_TRIES at worst.
//  - Because LD comes from state, CNT already reflects the new card in the following IDLE cycle.
//  Outputs
//  - LD, CLR and BUSY are decoded from state.
//  - POS=CARDS[1:0]; D=card register.
//  - FULL=(CARDS==4). The 5th DEAL is ignored, CARDS saturates at 4 and never wraps.
//  - BUST = (CNT > BUST_LIMIT) & (CARDS != 0) & (state != CLEAR).
//  - While BUST=1, DEAL edges are ignored until NEW_HAND.
// STRUCTURE
//  - bj_pkg: rank constants (RANK_ACE=1, RANK_EMPTY=4'hF, RANK_MAX=12), state enum {CLEAR, IDLE, DRAW, LOAD},
//    BJ_BUST_LIMIT, and the LFSR tap mask.
//  - Sub-module bj_lfsr16 (CLK, RST_N, SEED parameter, Q[15:0]): free-running LFSR.
//  - bj_card_dealer holds the FSM, edge detector, try counter and card counter.
// TESTING
//  - Reset: RST_N low, then release -> CLR=1 for one cycle after release, then IDLE; CARDS=0, LD=0, POS=0.
//  - Four deals: four DEAL pulses with CNT=5 -> LD pulses at POS 0,1,2,3 with D in 0..12, CARDS=4, FULL=1.
//    A 5th pulse -> no LD, BUSY stays 0.
//  - Rejection: SEED=16'h000F, DEAL edge timed so the first DRAW cycle sees 16'h000F.
//    -> Samples F and E are rejected, then 16'h003C is accepted: D=4'hC, LD high 4 cycles after the DEAL edge.
//  - Fallback: MAX_TRIES=1, DRAW sees nibble 4'hE -> D=4'h1, LD on the next cycle.
//  - Bust: after 2 cards drive CNT=22 -> BUST=1 and the next DEAL is ignored.
//    NEW_HAND -> CLR pulse, CARDS=0, BUST=0.
//  - Abort and simultaneous events:
//    - NEW_HAND asserted in DRAW -> next state CLEAR, no LD, CARDS=0.
//    - NEW_HAND and a DEAL edge in the same IDLE cycle -> only the clear happens.

Source files
------------

// File: rtl/bj_pkg.sv
// Shared constants for the blackjack card dealer: rank codes, FSM encoding,
// bust limit and the LFSR feedback rule.
package bj_pkg;

    localparam logic [3:0]  RANK_ACE      = 4'd1;
    localparam logic [3:0]  RANK_EMPTY    = 4'hF;
    localparam logic [3:0]  RANK_MAX      = 4'd12;
    localparam logic [3:0]  RANK_FOLD     = 4'd13;

    localparam logic [5:0]  BJ_BUST_LIMIT = 6'd21;

    // Feedback taps at bits 15, 13, 12 and 10
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;

    typedef logic [1:0] state_t;

    localparam state_t ST_CLEAR = 2'd0;
    localparam state_t ST_IDLE  = 2'd1;
    localparam state_t ST_DRAW  = 2'd2;
    localparam state_t ST_LOAD  = 2'd3;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bj_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, loaded with SEED on reset and shifted
// every cycle.
module bj_lfsr16
    import bj_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic [15:0] Q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign Q = lfsr_q;

endmodule

// File: rtl/bj_card_dealer.sv
// Card dealer: draws LFSR ranks into hand slots 0..3 via LD/POS/D, clears the
// hand on NEW_HAND and stops dealing once the hand total busts.
//
//  state | meaning
//  CLEAR | one-cycle clear strobe, card count reset
//  IDLE  | waiting for a deal edge
//  DRAW  | sampling the LFSR nibble, rejecting codes 13..15
//  LOAD  | one-cycle load strobe into slot CARDS
module bj_card_dealer
    import bj_pkg::*;
#(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          MAX_TRIES  = 8,
    parameter logic [5:0]  BUST_LIMIT = BJ_BUST_LIMIT
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       DEAL,
    input  logic       NEW_HAND,
    input  logic [5:0] CNT,
    output logic       LD,
    output logic [1:0] POS,
    output logic [3:0] D,
    output logic       CLR,
    output logic [2:0] CARDS,
    output logic       FULL,
    output logic       BUST,
    output logic       BUSY
);

    localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

    logic [15:0] lfsr_val;
    logic        lfsr_unused;
    logic [3:0]  draw_nib;

    state_t      state_q,   state_d;
    logic [3:0]  try_cnt_q, try_cnt_d;
    logic [3:0]  card_q,    card_d;
    logic [2:0]  cards_q,   cards_d;
    logic        deal_q,    deal_d;
    logic        deal_req;
    logic        full;
    logic        bust;

    bj_lfsr16 #(.SEED(SEED)) u_lfsr (
        .CLK   (CLK),
        .RST_N (RST_N),
        .Q     (lfsr_val)
    );

    assign draw_nib    = lfsr_val[3:0];
    assign lfsr_unused = ^lfsr_val[15:4];

    assign full = (cards_q == 3'd4);
    assign bust = (CNT > BUST_LIMIT) && (cards_q != 3'd0) && (state_q != ST_CLEAR);

    always_comb begin
        state_d   = state_q;
        try_cnt_d = try_cnt_q;
        card_d    = card_q;
        cards_d   = cards_q;
        deal_d    = DEAL;
        deal_req  = DEAL & ~deal_q;

        case (state_q)
            ST_CLEAR: begin
                cards_d = 3'd0;
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (deal_req && !full && !bust) begin
                    try_cnt_d = 4'd0;
                    state_d   = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (draw_nib <= RANK_MAX) begin
                    card_d  = draw_nib;
                    state_d = ST_LOAD;
                end else if (try_cnt_q == LAST_TRY) begin
                    // Fold 13..15 onto 0..2 so a draw always terminates
                    card_d  = draw_nib - RANK_FOLD;
                    state_d = ST_LOAD;
                end else begin
                    try_cnt_d = try_cnt_q + 4'd1;
                end
            end
            ST_LOAD: begin
                if (!full) begin
                    cards_d = cards_q + 3'd1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        if (NEW_HAND) begin
            state_d = ST_CLEAR;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_CLEAR;
            try_cnt_q <= 4'd0;
            card_q    <= 4'd0;
            cards_q   <= 3'd0;
            deal_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            try_cnt_q <= try_cnt_d;
            card_q    <= card_d;
            cards_q   <= cards_d;
            deal_q    <= deal_d;
        end
    end

    assign LD    = (state_q == ST_LOAD);
    assign CLR   = (state_q == ST_CLEAR);
    assign BUSY  = (state_q != ST_IDLE);
    assign POS   = cards_q[1:0];
    assign D     = card_q;
    assign CARDS = cards_q;
    assign FULL  = full;
    assign BUST  = bust;

endmodule

// File: tb/tb_bj_card_dealer.sv
// Randomized scoreboard bench for bj_card_dealer: two instances (default
// MAX_TRIES and MAX_TRIES=1) checked against a rule-level dealing model.
module tb_bj_card_dealer;

    localparam logic [15:0] SEED0 = 16'hACE1;
    localparam logic [15:0] SEED1 = 16'h1D2C;
    localparam int          MT0   = 8;
    localparam int          MT1   = 1;
    localparam int          LIMIT = 21;

    typedef struct {
        int pos;
        int d;
        int cyc;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       deal     [2];
    logic       new_hand [2];
    logic [5:0] cnt      [2];
    logic       ld       [2];
    logic [1:0] pos      [2];
    logic [3:0] d        [2];
    logic       clr      [2];
    logic [2:0] cards    [2];
    logic       full     [2];
    logic       bust     [2];
    logic       busy     [2];

    logic [15:0] m_lfsr  [2];
    int          m_cards [2];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_mis = 0;
    exp_t        q0[$];
    exp_t        q1[$];

    always #5 CLK = ~CLK;

    bj_card_dealer #(.SEED(SEED0), .MAX_TRIES(MT0)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .DEAL(deal[0]), .NEW_HAND(new_hand[0]), .CNT(cnt[0]),
        .LD(ld[0]), .POS(pos[0]), .D(d[0]), .CLR(clr[0]), .CARDS(cards[0]),
        .FULL(full[0]), .BUST(bust[0]), .BUSY(busy[0])
    );

    bj_card_dealer #(.SEED(SEED1), .MAX_TRIES(MT1)) u_fb (
        .CLK(CLK), .RST_N(RST_N), .DEAL(deal[1]), .NEW_HAND(new_hand[1]), .CNT(cnt[1]),
        .LD(ld[1]), .POS(pos[1]), .D(d[1]), .CLR(clr[1]), .CARDS(cards[1]),
        .FULL(full[1]), .BUST(bust[1]), .BUSY(busy[1])
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic fb;
        fb = v[15] ^ v[13] ^ v[12] ^ v[10];
        return {v[14:0], fb};
    endfunction

    // Rank drawn from successive LFSR values starting at v0, and how many draws were rejected
    function automatic void predict(input logic [15:0] v0, input int mt,
                                    output int card, output int extra);
        logic [15:0] v;
        int nib;
        v = v0;
        card = 0;
        extra = 0;
        for (int i = 0; i < mt; i++) begin
            nib = int'(v[3:0]);
            if (nib <= 12) begin
                card = nib;
                extra = i;
                return;
            end
            if (i == mt - 1) begin
                card = nib - 13;
                extra = i;
                return;
            end
            v = lfsr_step(v);
        end
    endfunction

    function automatic int mt_of(input int inst);
        return (inst == 0) ? MT0 : MT1;
    endfunction

    function automatic int qsize(input int inst);
        return (inst == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int exp_bust(input int inst);
        return ((int'(cnt[inst]) > LIMIT) && (m_cards[inst] != 0)) ? 1 : 0;
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_lfsr[0] <= SEED0;
            m_lfsr[1] <= SEED1;
        end else begin
            m_lfsr[0] <= lfsr_step(m_lfsr[0]);
            m_lfsr[1] <= lfsr_step(m_lfsr[1]);
        end
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin : mon0
        exp_t e;
        if (RST_N && ld[0]) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL ld0_unexpected: got LD=1 at cycle %0d, expected LD=0", cyc);
            end else begin
                e = q0.pop_front();
                chk("ld0_pos", int'(pos[0]), e.pos);
                chk("ld0_d", int'(d[0]), e.d);
                chk("ld0_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge CLK) begin : mon1
        exp_t e;
        if (RST_N && ld[1]) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL ld1_unexpected: got LD=1 at cycle %0d, expected LD=0", cyc);
            end else begin
                e = q1.pop_front();
                chk("ld1_pos", int'(pos[1]), e.pos);
                chk("ld1_d", int'(d[1]), e.d);
                chk("ld1_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_deal(input int inst);
        int   card;
        int   extra;
        int   k;
        bit   acc;
        exp_t e;
        acc = (m_cards[inst] < 4) && (exp_bust(inst) == 0);
        deal[inst] = 1'b1;
        if (acc) begin
            predict(lfsr_step(m_lfsr[inst]), mt_of(inst), card, extra);
            e.pos = m_cards[inst];
            e.d   = card;
            e.cyc = cyc + 2 + extra;
            if (inst == 0) q0.push_back(e);
            else           q1.push_back(e);
        end
        tick();
        deal[inst] = 1'b0;
        if (acc) begin
            k = 0;
            while (qsize(inst) != 0 && k < 40) begin
                tick();
                k++;
            end
            if (qsize(inst) != 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL deal_timeout: inst %0d got no LD within 40 cycles, expected one", inst);
                if (inst == 0) q0.delete();
                else           q1.delete();
            end
            m_cards[inst]++;
        end else begin
            repeat (3) begin
                tick();
                chk("ignored_busy", int'(busy[inst]), 0);
            end
        end
        chk("cards", int'(cards[inst]), m_cards[inst]);
        chk("full", int'(full[inst]), (m_cards[inst] == 4) ? 1 : 0);
        chk("busy_idle", int'(busy[inst]), 0);
        chk("bust", int'(bust[inst]), exp_bust(inst));
    endtask

    task automatic do_new_hand(input int inst);
        new_hand[inst] = 1'b1;
        tick();
        new_hand[inst] = 1'b0;
        chk("clr_pulse", int'(clr[inst]), 1);
        chk("bust_in_clear", int'(bust[inst]), 0);
        tick();
        m_cards[inst] = 0;
        chk("clr_done", int'(clr[inst]), 0);
        chk("cards_cleared", int'(cards[inst]), 0);
        chk("busy_after_clear", int'(busy[inst]), 0);
        chk("bust_after_clear", int'(bust[inst]), 0);
    endtask

    task automatic ensure_dealable(input int inst);
        if (m_cards[inst] == 4 || exp_bust(inst) != 0) do_new_hand(inst);
    endtask

    task automatic do_abort();
        ensure_dealable(0);
        deal[0] = 1'b1;
        tick();
        deal[0] = 1'b0;
        chk("abort_in_draw", int'(busy[0]), 1);
        new_hand[0] = 1'b1;
        tick();
        new_hand[0] = 1'b0;
        chk("abort_clr", int'(clr[0]), 1);
        chk("abort_no_ld", int'(ld[0]), 0);
        tick();
        m_cards[0] = 0;
        chk("abort_cards", int'(cards[0]), 0);
        chk("abort_busy", int'(busy[0]), 0);
    endtask

    task automatic do_simul();
        ensure_dealable(0);
        deal[0] = 1'b1;
        new_hand[0] = 1'b1;
        tick();
        deal[0] = 1'b0;
        new_hand[0] = 1'b0;
        chk("simul_clr", int'(clr[0]), 1);
        m_cards[0] = 0;
        repeat (3) begin
            tick();
            chk("simul_busy", int'(busy[0]), 0);
        end
        chk("simul_cards", int'(cards[0]), 0);
    endtask

    function automatic bit reject_pattern(input logic [15:0] cur);
        logic [15:0] v0, v1, v2;
        v0 = lfsr_step(cur);
        v1 = lfsr_step(v0);
        v2 = lfsr_step(v1);
        return (v0[3:0] > 4'd12) && (v1[3:0] > 4'd12) && (v2[3:0] <= 4'd12);
    endfunction

    initial begin
        int k;
        int act;
        logic [15:0] nxt;
        for (int i = 0; i < 2; i++) begin
            deal[i] = 1'b0;
            new_hand[i] = 1'b0;
            cnt[i] = 6'd0;
            m_cards[i] = 0;
        end

        #3;
        chk("rst_clr", int'(clr[0]), 1);
        chk("rst_ld", int'(ld[0]), 0);
        chk("rst_pos", int'(pos[0]), 0);
        chk("rst_d", int'(d[0]), 0);
        chk("rst_full", int'(full[0]), 0);
        chk("rst_bust", int'(bust[0]), 0);
        chk("rst_busy", int'(busy[0]), 1);
        chk("rst_cards", int'(cards[0]), 0);
        chk("rst_fb_clr", int'(clr[1]), 1);
        tick();
        tick();
        RST_N = 1'b1;
        #1;
        chk("rel_clr_high", int'(clr[0]), 1);
        tick();
        chk("rel_clr_low", int'(clr[0]), 0);
        chk("rel_busy", int'(busy[0]), 0);
        chk("rel_cards", int'(cards[0]), 0);
        chk("rel_ld", int'(ld[0]), 0);
        chk("rel_pos", int'(pos[0]), 0);

        // Four deals fill the hand; the fifth is ignored
        cnt[0] = 6'd5;
        repeat (5) do_deal(0);
        do_new_hand(0);

        // Bust after two cards blocks further deals until NEW_HAND
        do_deal(0);
        do_deal(0);
        cnt[0] = 6'd22;
        #1;
        chk("bust_set", int'(bust[0]), 1);
        do_deal(0);
        do_new_hand(0);
        cnt[0] = 6'd5;

        do_abort();
        do_simul();

        // Time a deal so its first two draws are rejected
        k = 0;
        while (!reject_pattern(m_lfsr[0]) && k < 3000) begin
            tick();
            k++;
        end
        if (!reject_pattern(m_lfsr[0])) begin
            n_cmp++;
            n_mis++;
            $display("FAIL reject_setup: got no double-reject LFSR window in 3000 cycles, expected one");
        end
        do_deal(0);

        // Fallback path on the single-try instance: nibble E folds to ace
        for (int r = 0; r < 4; r++) begin
            ensure_dealable(1);
            k = 0;
            nxt = lfsr_step(m_lfsr[1]);
            while (nxt[3:0] != 4'hE && k < 500) begin
                tick();
                k++;
                nxt = lfsr_step(m_lfsr[1]);
            end
            if (nxt[3:0] != 4'hE) begin
                n_cmp++;
                n_mis++;
                $display("FAIL fallback_setup: got no E nibble window in 500 cycles, expected one");
            end
            do_deal(1);
        end

        for (int it = 0; it < 150; it++) begin
            int inst;
            inst = $urandom_range(0, 1);
            act = $urandom_range(0, 99);
            if (act < 65) begin
                cnt[inst] = 6'($urandom_range(0, 30));
                do_deal(inst);
            end else if (act < 80) begin
                do_new_hand(inst);
            end else if (act < 92) begin
                repeat ($urandom_range(1, 5)) tick();
            end else if (act < 96) begin
                do_abort();
            end else begin
                do_simul();
            end
        end

        repeat (4) tick();
        chk("final_q0_empty", q0.size(), 0);
        chk("final_q1_empty", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
